// File: rtl/dmem_lat.sv
// dmem_lat: word RAM with byte strobes and a programmable-latency req/ack/stall handshake
module dmem_lat #(
  parameter int    DEPTH     = 64,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_be,
  input  logic [31:0] i_wd,
  output logic [31:0] o_rd,
  output logic        o_ack,
  output logic        o_stall,
  output logic        o_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} stateT;
  logic [31:0] mem [DEPTH];
  stateT state, nextState;
  logic [3:0] cnt, nextCnt;
  logic [31:0] rdReg;
  logic [AW-1:0] idx;
  logic outOfRange, doWrite;
  logic [1:0] unusedAddrLsb;
  assign idx = i_addr[AW+1:2];
  assign outOfRange = |i_addr[31:AW+2];
  assign unusedAddrLsb = i_addr[1:0];
  // next-state: count down the wait cycles, abandon the access if the request vanishes
  always_comb begin
    nextState = state;
    nextCnt = cnt;
    case (state)
      IDLE: if (i_req) begin
        nextState = (LATENCY == 1) ? DONE : WAIT;
        nextCnt = 4'(LATENCY - 1);
      end
      WAIT: if (!i_req) nextState = IDLE;
        else if (cnt == 4'd1) nextState = DONE;
        else nextCnt = cnt - 4'd1;
      default: nextState = IDLE;
    endcase
  end
  // state register; read data is captured on entry to DONE and held otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rdReg <= '0;
    end else begin
      state <= nextState;
      cnt <= nextCnt;
      if (nextState == DONE) rdReg <= outOfRange ? '0 : i_we ? rdReg : mem[idx];
    end
  end
  assign doWrite = ((LATENCY == 0) ? i_req : (state == DONE)) & i_we & ~outOfRange & ~rst;
  // byte-lane write at the edge that ends the ack cycle; RAM is never cleared by reset
  always_ff @(posedge clk) begin
    if (doWrite)
      for (int b = 0; b < 4; b++)
        if (i_be[b]) mem[idx][8*b +: 8] <= i_wd[8*b +: 8];
  end
  assign o_ack = (LATENCY == 0) ? i_req : (state == DONE);
  assign o_stall = i_req & ~o_ack;
  assign o_err = o_ack & outOfRange;
  assign o_rd = (LATENCY == 0) ? (outOfRange ? '0 : mem[idx]) : rdReg;
endmodule

// File: tb/tb_dmem_lat.sv
// tb_dmem_lat: directed checks of dmem_lat at latencies 0, 2, 3 and 4
module tb_dmem_lat;
  logic clk = 0, rst = 1;
  logic req [4];
  logic we = 0;
  logic [31:0] addr = '0, wd = '0;
  logic [3:0] be = '0;
  logic [31:0] rd [4];
  logic ack [4], stall [4], err [4];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  dmem_lat #(.LATENCY(0)) u0 (.clk(clk), .rst(rst), .i_req(req[0]), .i_we(we), .i_addr(addr), .i_be(be), .i_wd(wd),
    .o_rd(rd[0]), .o_ack(ack[0]), .o_stall(stall[0]), .o_err(err[0]));
  dmem_lat #(.LATENCY(2)) u2 (.clk(clk), .rst(rst), .i_req(req[1]), .i_we(we), .i_addr(addr), .i_be(be), .i_wd(wd),
    .o_rd(rd[1]), .o_ack(ack[1]), .o_stall(stall[1]), .o_err(err[1]));
  dmem_lat #(.LATENCY(3)) u3 (.clk(clk), .rst(rst), .i_req(req[2]), .i_we(we), .i_addr(addr), .i_be(be), .i_wd(wd),
    .o_rd(rd[2]), .o_ack(ack[2]), .o_stall(stall[2]), .o_err(err[2]));
  dmem_lat #(.LATENCY(4)) u4 (.clk(clk), .rst(rst), .i_req(req[3]), .i_we(we), .i_addr(addr), .i_be(be), .i_wd(wd),
    .o_rd(rd[3]), .o_ack(ack[3]), .o_stall(stall[3]), .o_err(err[3]));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic access(input int u, input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                        output int ac, output logic [31:0] r, output logic e, output logic [15:0] sm);
    req[u] = 1; we = w; addr = a; be = b; wd = d;
    ac = -1; r = '0; e = 0; sm = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      sm[c] = stall[u];
      if (ack[u]) begin
        ac = c; r = rd[u]; e = err[u];
      end
      tick();
      if (ac >= 0) break;
    end
    req[u] = 0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    for (int u = 1; u < 4; u++) begin
      checks++; if (ack[u] !== 1'b0) begin errors++; $display("FAIL reset_ack[%0d]: got %b want 0", u, ack[u]); end
      checks++; if (err[u] !== 1'b0) begin errors++; $display("FAIL reset_err[%0d]: got %b want 0", u, err[u]); end
      checks++; if (rd[u] !== 32'h0) begin errors++; $display("FAIL reset_rd[%0d]: got %h want 0", u, rd[u]); end
      checks++; if (stall[u] !== 1'b0) begin errors++; $display("FAIL reset_stall[%0d]: got %b want 0", u, stall[u]); end
    end
    tick();
  endtask

  task automatic test_basic;
    int ac; logic [31:0] r; logic e; logic [15:0] sm;
    access(1, 1, 32'h10, 4'hF, 32'hDEADBEEF, ac, r, e, sm);
    checks++; if (ac !== 2) begin errors++; $display("FAIL l2_write_ackcyc: got %0d want 2", ac); end
    checks++; if (sm !== 16'b011) begin errors++; $display("FAIL l2_write_stall: got %b want 011", sm); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL l2_write_err: got %b want 0", e); end
    access(1, 0, 32'h10, 4'h0, 32'h0, ac, r, e, sm);
    checks++; if (ac !== 2) begin errors++; $display("FAIL l2_read_ackcyc: got %0d want 2", ac); end
    checks++; if (sm !== 16'b011) begin errors++; $display("FAIL l2_read_stall: got %b want 011", sm); end
    checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL l2_read_rd: got %h want deadbeef", r); end
  endtask

  task automatic test_byte_strobes;
    int ac; logic [31:0] r; logic e; logic [15:0] sm;
    access(1, 1, 32'h0, 4'hF, 32'h11223344, ac, r, e, sm);
    access(1, 1, 32'h0, 4'b0100, 32'hAABBCCDD, ac, r, e, sm);
    access(1, 0, 32'h0, 4'h0, 32'h0, ac, r, e, sm);
    checks++; if (r !== 32'h11BB3344) begin errors++; $display("FAIL byte_strobe_rd: got %h want 11bb3344", r); end
    access(1, 1, 32'h0, 4'h0, 32'hFFFFFFFF, ac, r, e, sm);
    checks++; if (ac !== 2) begin errors++; $display("FAIL be0_ackcyc: got %0d want 2", ac); end
    access(1, 0, 32'h0, 4'h0, 32'h0, ac, r, e, sm);
    checks++; if (r !== 32'h11BB3344) begin errors++; $display("FAIL be0_unchanged: got %h want 11bb3344", r); end
  endtask

  task automatic test_range;
    int ac; logic [31:0] r; logic e; logic [15:0] sm;
    access(1, 0, 32'h100, 4'h0, 32'h0, ac, r, e, sm);
    checks++; if (ac !== 2) begin errors++; $display("FAIL range_read_ackcyc: got %0d want 2", ac); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL range_read_err: got %b want 1", e); end
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL range_read_rd: got %h want 0", r); end
    access(1, 1, 32'h100, 4'hF, 32'hFFFFFFFF, ac, r, e, sm);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL range_write_err: got %b want 1", e); end
    access(1, 0, 32'h0, 4'h0, 32'h0, ac, r, e, sm);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL inrange_err: got %b want 0", e); end
    checks++; if (r !== 32'h11BB3344) begin errors++; $display("FAIL range_mem0: got %h want 11bb3344", r); end
  endtask

  task automatic test_reset_mid;
    int ac; logic [31:0] r; logic e; logic [15:0] sm;
    logic sawAck = 0;
    access(3, 1, 32'h8, 4'hF, 32'h01020304, ac, r, e, sm);
    checks++; if (ac !== 4) begin errors++; $display("FAIL l4_write_ackcyc: got %0d want 4", ac); end
    access(3, 0, 32'h8, 4'h0, 32'h0, ac, r, e, sm);
    checks++; if (r !== 32'h01020304) begin errors++; $display("FAIL l4_read_rd: got %h want 01020304", r); end
    req[3] = 1; we = 1; addr = 32'h8; be = 4'hF; wd = 32'h55AA55AA;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) rst = 1;
      @(negedge clk);
      if (ack[3]) sawAck = 1;
      tick();
    end
    rst = 0; req[3] = 0;
    @(negedge clk);
    if (ack[3]) sawAck = 1;
    checks++; if (sawAck !== 1'b0) begin errors++; $display("FAIL reset_mid_ack: got %b want 0", sawAck); end
    checks++; if (rd[3] !== 32'h0) begin errors++; $display("FAIL reset_mid_rd: got %h want 0", rd[3]); end
    tick();
    access(3, 0, 32'h8, 4'h0, 32'h0, ac, r, e, sm);
    checks++; if (ac !== 4) begin errors++; $display("FAIL post_reset_ackcyc: got %0d want 4", ac); end
    checks++; if (r !== 32'h01020304) begin errors++; $display("FAIL post_reset_old: got %h want 01020304", r); end
  endtask

  task automatic test_lat0;
    int ac; logic [31:0] r; logic e; logic [15:0] sm;
    access(0, 1, 32'h4, 4'hF, 32'hCAFEF00D, ac, r, e, sm);
    checks++; if (ac !== 0) begin errors++; $display("FAIL l0_write_ackcyc: got %0d want 0", ac); end
    access(0, 0, 32'h4, 4'h0, 32'h0, ac, r, e, sm);
    checks++; if (ac !== 0) begin errors++; $display("FAIL l0_read_ackcyc: got %0d want 0", ac); end
    checks++; if (sm !== 16'h0) begin errors++; $display("FAIL l0_stall: got %b want 0", sm); end
    checks++; if (r !== 32'hCAFEF00D) begin errors++; $display("FAIL l0_read_rd: got %h want cafef00d", r); end
    access(0, 1, 32'h0, 4'hF, 32'h0BADC0DE, ac, r, e, sm);
    req[0] = 1; we = 0; addr = 32'h4;
    #1;
    checks++; if (rd[0] !== 32'hCAFEF00D) begin errors++; $display("FAIL l0_comb_a: got %h want cafef00d", rd[0]); end
    addr = 32'h0;
    #1;
    checks++; if (rd[0] !== 32'h0BADC0DE) begin errors++; $display("FAIL l0_comb_b: got %h want 0badc0de", rd[0]); end
    checks++; if (ack[0] !== 1'b1) begin errors++; $display("FAIL l0_comb_ack: got %b want 1", ack[0]); end
    req[0] = 0;
    tick();
  endtask

  task automatic test_back_to_back;
    int ac; logic [31:0] r; logic e; logic [15:0] sm;
    int n = 0, first = -1, last = -1;
    logic dataOk = 1;
    access(2, 1, 32'hC, 4'hF, 32'h12345678, ac, r, e, sm);
    checks++; if (ac !== 3) begin errors++; $display("FAIL l3_write_ackcyc: got %0d want 3", ac); end
    req[2] = 1; we = 0; addr = 32'hC;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ack[2]) begin
        n++;
        if (first < 0) first = c;
        last = c;
        if (rd[2] !== 32'h12345678) dataOk = 0;
      end
      tick();
    end
    req[2] = 0;
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", n); end
    checks++; if (first !== 3) begin errors++; $display("FAIL b2b_first: got %0d want 3", first); end
    checks++; if (last !== 11) begin errors++; $display("FAIL b2b_last: got %0d want 11", last); end
    checks++; if (dataOk !== 1'b1) begin errors++; $display("FAIL b2b_data: got %b want 1", dataOk); end
  endtask

  task automatic test_drop;
    int ac; logic [31:0] r; logic e; logic [15:0] sm;
    logic sawAck = 0, sawStall = 0;
    req[2] = 1; we = 0; addr = 32'hC;
    tick();
    req[2] = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ack[2]) sawAck = 1;
      if (stall[2]) sawStall = 1;
      tick();
    end
    checks++; if (sawAck !== 1'b0) begin errors++; $display("FAIL drop_ack: got %b want 0", sawAck); end
    checks++; if (sawStall !== 1'b0) begin errors++; $display("FAIL drop_stall: got %b want 0", sawStall); end
    access(2, 0, 32'hC, 4'h0, 32'h0, ac, r, e, sm);
    checks++; if (ac !== 3) begin errors++; $display("FAIL drop_next_ackcyc: got %0d want 3", ac); end
    checks++; if (r !== 32'h12345678) begin errors++; $display("FAIL drop_next_rd: got %h want 12345678", r); end
  endtask

  initial begin
    for (int u = 0; u < 4; u++) req[u] = 0;
    tick();
    tick();
    rst = 0;
    test_reset();
    test_basic();
    test_byte_strobes();
    test_range();
    test_reset_mid();
    test_lat0();
    test_back_to_back();
    test_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
